uart_tx_buffer: RTL and testbench

Buffered 8N1 UART transmitter: accepts bytes over a valid/ready write port into a small FIFO and serialises them on `tx` at a fixed clocks-per-bit rate. It is the transmit counterpart of UartRxBuffer and uses the same 100 MHz / 115200 baud timing (868 clocks per bit). Frames are LSB-first with one start bit, eight data bits, one stop bit and no parity. It sits between the command/response logic and the board TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 74 +++++++
 rtl/uart_tx_buffer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit buffer and the matching receiver.
package uart_pkg;

  // 100 MHz system clock, 115200 baud.
  localparam int UART_CLKS_PER_BIT = 868;

  // Payload width of one 8N1 frame.
  localparam int UART_DATA_W = 8;

  // Index of the final data bit; the FSM leaves DATA after this one.
  localparam logic [2:0] UART_LAST_BIT = 3'd7;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small circular FIFO holding bytes waiting to be serialised.
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate occupancy counter; wrap-around is natural overflow.
// The head entry is presented combinationally on dout so the FSM can
// load it into its shift register in the same cycle it pops.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Full: same slot, opposite lap. Empty: identical pointers.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A push while full is dropped; a pop while empty is ignored.
  // Push and pop in the same cycle both take effect.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter.
// Bytes enter through a valid/ready write port into uart_tx_fifo and are
// shifted out LSB-first with one start and one stop bit. When a stop bit
// ends with more data queued, the next start bit follows with no idle gap.
// tx is registered and derived from the next state, so the line changes
// on the same edge that the FSM moves.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,  // at least 2
  parameter int DEPTH        = 4                   // power of 2, at least 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] data,
  input  logic                   write,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  uart_tx_state_t         state_q;
  uart_tx_state_t         state_d;
  logic [BAUD_W-1:0]      baud_q;
  logic [BAUD_W-1:0]      baud_d;
  logic [2:0]             bit_idx_q;
  logic [2:0]             bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] shift_d;
  logic                   tx_q;
  logic                   tx_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   bit_done;

  // Byte queue; the FIFO itself drops writes arriving while it is full.
  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (write),
    .pop   (fifo_pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Last clock of the current bit period.
  assign bit_done = (baud_q == BAUD_LAST);

  // ready comes straight from the registered pointers, so a pop while full
  // only raises it on the following cycle.
  assign ready = !fifo_full;
  assign busy  = (state_q != IDLE) || !fifo_empty;
  assign tx    = tx_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; also decides when the head of the FIFO is consumed.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done && (bit_idx_q == UART_LAST_BIT)) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Baud counter, bit index and shift register updates.
  always_comb begin
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (fifo_pop) begin
      // A fresh frame: load the byte and restart the bit timing.
      shift_d   = fifo_dout;
      baud_d    = '0;
      bit_idx_d = '0;
    end else if (state_q != IDLE) begin
      if (bit_done) begin
        baud_d = '0;
        if (state_q == DATA) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_idx_d = '0;
        end
      end else begin
        baud_d = baud_q + BAUD_ONE;
      end
    end
  end

  // Line level for the state being entered; registered below.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath registers; reset forces the line idle and clears counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: three instances (8, 3 and 868 clocks per
// bit) checked cycle by cycle against a frame-schedule model, with a
// mid-bit line decoder recovering the transmitted bytes.
`timescale 1ns/1ps
module tb_uart_tx_buffer;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  function automatic int cpb_of(input int id);
    case (id)
      0:       return 8;
      1:       return 3;
      default: return 868;
    endcase
  endfunction

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       wr      [NI];
  logic [7:0] din     [NI];
  logic       tx_w    [NI];
  logic       ready_w [NI];
  logic       busy_w  [NI];

  int total = 0;
  int bad   = 0;
  int rst_epoch = 0;

  // Bytes recovered from each tx line.
  logic [7:0] dec_q [NI][64];
  int         dec_n [NI];

  // Reference model: queued bytes, the frame on the line and its age.
  logic [7:0] m_buf   [NI][16];
  int         m_rd    [NI];
  int         m_wr    [NI];
  int         m_t     [NI];
  logic       m_act   [NI];
  logic [7:0] m_frame [NI];
  logic [7:0] m_acc   [NI][64];
  int         m_acc_n [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CPB = cpb_of(gi);

    uart_tx_buffer #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .data  (din[gi]),
      .write (wr[gi]),
      .ready (ready_w[gi]),
      .tx    (tx_w[gi]),
      .busy  (busy_w[gi])
    );

    // Line decoder: samples each bit near its middle on falling clock edges.
    initial begin : decode
      int ep;
      logic [7:0] b;
      dec_n[gi] = 0;
      forever begin
        @(negedge tx_w[gi]);
        ep = rst_epoch;
        repeat (CPB / 2 + 1) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx_w[gi];
        end
        repeat (CPB) @(negedge clk);
        if (ep == rst_epoch && tx_w[gi] === 1'b1 && dec_n[gi] < 64) begin
          dec_q[gi][dec_n[gi]] = b;
          dec_n[gi] = dec_n[gi] + 1;
          $display("inst %0d frame %0d byte %02h", gi, dec_n[gi], b);
        end
      end
    end
  end

  function automatic int m_size(input int id);
    return m_wr[id] - m_rd[id];
  endfunction

  function automatic logic m_busy(input int id);
    return m_act[id] || (m_size(id) > 0);
  endfunction

  function automatic logic m_ready(input int id);
    return m_size(id) < DEPTH;
  endfunction

  // Frame bit k: 0 start, 1..8 data LSB-first, 9 stop.
  function automatic logic m_tx(input int id);
    int k;
    if (!m_act[id]) return 1'b1;
    k = m_t[id] / cpb_of(id);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_frame[id][k-1];
  endfunction

  // One clock edge of the model, using the queue contents before the edge.
  task automatic model_edge(input int id, input logic w, input logic [7:0] d);
    int sz;
    int flen;
    sz   = m_size(id);
    flen = 10 * cpb_of(id);
    if (m_act[id] && m_t[id] < flen - 1) begin
      m_t[id] = m_t[id] + 1;
    end else if (sz > 0) begin
      m_frame[id] = m_buf[id][m_rd[id] % 16];
      m_rd[id]    = m_rd[id] + 1;
      m_act[id]   = 1'b1;
      m_t[id]     = 0;
    end else begin
      m_act[id] = 1'b0;
    end
    if (w && sz < DEPTH) begin
      m_buf[id][m_wr[id] % 16] = d;
      m_wr[id] = m_wr[id] + 1;
      if (m_acc_n[id] < 64) begin
        m_acc[id][m_acc_n[id]] = d;
        m_acc_n[id] = m_acc_n[id] + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_rd[i]  = 0;
      m_wr[i]  = 0;
      m_t[i]   = 0;
      m_act[i] = 1'b0;
    end
  endtask

  // Drive one instance (id < 0: none), take one edge, sample 1 ns later.
  task automatic step(input int id, input logic w, input logic [7:0] d);
    for (int i = 0; i < NI; i++) begin
      wr[i]  = (i == id) ? w : 1'b0;
      din[i] = (i == id) ? d : 8'h00;
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i, wr[i], din[i]);
    #1;
    for (int i = 0; i < NI; i++) wr[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rst_epoch = rst_epoch + 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({tx_w[i], busy_w[i], ready_w[i]} !== 3'b101) begin
        bad++;
        $display("FAIL reset_hold inst %0d: tx/busy/ready got %b want 101", i,
                 {tx_w[i], busy_w[i], ready_w[i]});
      end
    end
    reset = 1'b0;
    step(-1, 1'b0, 8'h00);
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({tx_w[i], busy_w[i], ready_w[i]} !== 3'b101) begin
        bad++;
        $display("FAIL reset_release inst %0d: tx/busy/ready got %b want 101", i,
                 {tx_w[i], busy_w[i], ready_w[i]});
      end
    end
  endtask

  task automatic test_single();
    int base;
    int fall;
    base = dec_n[0];
    fall = -1;
    step(0, 1'b1, 8'h55);
    for (int c = 0; c < 86; c++) begin
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== {m_tx(0), m_busy(0), m_ready(0)}) begin
        bad++;
        $display("FAIL single cycle %0d: tx/busy/ready got %b want %b", c,
                 {tx_w[0], busy_w[0], ready_w[0]}, {m_tx(0), m_busy(0), m_ready(0)});
      end
      if (fall < 0 && tx_w[0] === 1'b0) fall = c;
      step(-1, 1'b0, 8'h00);
    end
    total++;
    if (fall !== 1) begin
      bad++;
      $display("FAIL start_latency: got %0d want 1", fall);
    end
    total++;
    if (dec_n[0] - base !== 1 || dec_q[0][base] !== 8'h55) begin
      bad++;
      $display("FAIL single_decode: got n=%0d byte %02h want n=1 byte 55",
               dec_n[0] - base, dec_q[0][base]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int base;
    int n;
    int nfall;
    int last_fall;
    logic prev;
    bytes = '{8'hA3, 8'h00, 8'hFF};
    base = dec_n[0];
    nfall = 0;
    last_fall = 0;
    prev = tx_w[0];
    n = 0;
    for (int k = 0; k < 3; k++) step(0, 1'b1, bytes[k]);
    while ((busy_w[0] === 1'b1 || m_busy(0)) && n < 400) begin
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== {m_tx(0), m_busy(0), m_ready(0)}) begin
        bad++;
        $display("FAIL b2b cycle %0d: tx/busy/ready got %b want %b", n,
                 {tx_w[0], busy_w[0], ready_w[0]}, {m_tx(0), m_busy(0), m_ready(0)});
      end
      if (prev === 1'b1 && tx_w[0] === 1'b0 && m_t[0] == 0) begin
        if (nfall > 0) begin
          total++;
          if (n - last_fall !== 80) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 80", n - last_fall);
          end
        end
        nfall++;
        last_fall = n;
      end
      prev = tx_w[0];
      step(-1, 1'b0, 8'h00);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL b2b_timeout: busy still %b after %0d cycles want 0", busy_w[0], n);
    end
    repeat (4) step(-1, 1'b0, 8'h00);
    total++;
    if (dec_n[0] - base !== 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 3", dec_n[0] - base);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (dec_q[0][base + k] !== bytes[k]) begin
        bad++;
        $display("FAIL b2b_byte %0d: got %02h want %02h", k, dec_q[0][base + k], bytes[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6];
    int base;
    int n;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
    base = dec_n[0];
    for (int k = 0; k < 6; k++) begin
      step(0, 1'b1, bytes[k]);
      if (k >= 4) begin
        total++;
        if (ready_w[0] !== 1'b0) begin
          bad++;
          $display("FAIL ovf_ready after write %0d: got %b want 0", k + 1, ready_w[0]);
        end
      end
    end
    n = 0;
    while ((busy_w[0] === 1'b1 || m_busy(0)) && n < 600) begin
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== {m_tx(0), m_busy(0), m_ready(0)}) begin
        bad++;
        $display("FAIL ovf cycle %0d: tx/busy/ready got %b want %b", n,
                 {tx_w[0], busy_w[0], ready_w[0]}, {m_tx(0), m_busy(0), m_ready(0)});
      end
      step(-1, 1'b0, 8'h00);
      n++;
    end
    total++;
    if (n >= 600) begin
      bad++;
      $display("FAIL ovf_timeout: busy still %b want 0", busy_w[0]);
    end
    repeat (4) step(-1, 1'b0, 8'h00);
    total++;
    if (dec_n[0] - base !== 5) begin
      bad++;
      $display("FAIL ovf_count: got %0d want 5", dec_n[0] - base);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (dec_q[0][base + k] !== bytes[k]) begin
        bad++;
        $display("FAIL ovf_byte %0d: got %02h want %02h", k, dec_q[0][base + k], bytes[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    step(0, 1'b1, 8'h0F);
    for (int c = 0; c < 30; c++) begin
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== {m_tx(0), m_busy(0), m_ready(0)}) begin
        bad++;
        $display("FAIL rstmid cycle %0d: tx/busy/ready got %b want %b", c,
                 {tx_w[0], busy_w[0], ready_w[0]}, {m_tx(0), m_busy(0), m_ready(0)});
      end
      step(-1, 1'b0, 8'h00);
    end
    // Assert reset between edges: the line must go idle without a clock.
    reset = 1'b1;
    rst_epoch = rst_epoch + 1;
    model_reset();
    #1;
    total++;
    if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
      bad++;
      $display("FAIL rstmid_async: tx/busy/ready got %b want 101",
               {tx_w[0], busy_w[0], ready_w[0]});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step(-1, 1'b0, 8'h00);
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
        bad++;
        $display("FAIL rstmid_idle cycle %0d: tx/busy/ready got %b want 101", c,
                 {tx_w[0], busy_w[0], ready_w[0]});
      end
    end
    base = dec_n[0];
    step(0, 1'b1, 8'h3C);
    for (int c = 0; c < 86; c++) begin
      total++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== {m_tx(0), m_busy(0), m_ready(0)}) begin
        bad++;
        $display("FAIL rstmid_after cycle %0d: tx/busy/ready got %b want %b", c,
                 {tx_w[0], busy_w[0], ready_w[0]}, {m_tx(0), m_busy(0), m_ready(0)});
      end
      step(-1, 1'b0, 8'h00);
    end
    total++;
    if (dec_n[0] - base !== 1 || dec_q[0][base] !== 8'h3C) begin
      bad++;
      $display("FAIL rstmid_decode: got n=%0d byte %02h want n=1 byte 3c",
               dec_n[0] - base, dec_q[0][base]);
    end
  endtask

  // Random write traffic on one instance, then drain and compare bytes.
  task automatic test_random(input int id, input int cycles, input int budget);
    int base;
    int acc0;
    int n;
    int got;
    int want;
    base = dec_n[id];
    acc0 = m_acc_n[id];
    for (int c = 0; c < cycles; c++) begin
      step(id, ($urandom_range(0, 2) == 0), 8'($urandom));
      total++;
      if ({tx_w[id], busy_w[id], ready_w[id]} !== {m_tx(id), m_busy(id), m_ready(id)}) begin
        bad++;
        $display("FAIL rand inst %0d cycle %0d: tx/busy/ready got %b want %b", id, c,
                 {tx_w[id], busy_w[id], ready_w[id]}, {m_tx(id), m_busy(id), m_ready(id)});
      end
    end
    n = 0;
    while ((busy_w[id] === 1'b1 || m_busy(id)) && n < budget) begin
      step(-1, 1'b0, 8'h00);
      total++;
      if ({tx_w[id], busy_w[id], ready_w[id]} !== {m_tx(id), m_busy(id), m_ready(id)}) begin
        bad++;
        $display("FAIL drain inst %0d cycle %0d: tx/busy/ready got %b want %b", id, n,
                 {tx_w[id], busy_w[id], ready_w[id]}, {m_tx(id), m_busy(id), m_ready(id)});
      end
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout inst %0d: busy got %b want 0", id, busy_w[id]);
    end
    repeat (4) step(-1, 1'b0, 8'h00);
    got  = dec_n[id] - base;
    want = m_acc_n[id] - acc0;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL rand_count inst %0d: got %0d want %0d", id, got, want);
    end
    for (int k = 0; k < want && k < got; k++) begin
      total++;
      if (dec_q[id][base + k] !== m_acc[id][acc0 + k]) begin
        bad++;
        $display("FAIL rand_byte inst %0d idx %0d: got %02h want %02h", id, k,
                 dec_q[id][base + k], m_acc[id][acc0 + k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      wr[i]      = 1'b0;
      din[i]     = 8'h00;
      m_acc_n[i] = 0;
    end
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_random(0, 300, 600);
    test_random(1, 120, 300);
    test_random(2, 3, 30000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
